tcp_tx_seg_gen: RTL and testbench

Transmit-side segment generator for the slow TCP engine, the send-direction counterpart of the receive pipeline. It accepts a flow ID from the TX scheduler and reads that flow's send state (sequence number, ACK number, peer window, send and tail payload pointers). It sizes the next segment, writes the advanced state back, and enqueues a header descriptor to the send-packet queue.

---
 rtl/tcp_tx_seg_gen_if.sv | 60 ++++++
 rtl/tcp_tx_seg_gen.sv | 134 +++++++++++++
 tb/tb_tcp_tx_seg_gen.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/tcp_tx_seg_gen_if.sv
// Handshake bundle for tcp_tx_seg_gen: scheduler command, state read/write ports,
// advertised window input and the send-packet descriptor queue.
interface tcp_tx_seg_gen_if #(
  parameter int FLOWID_W = 3,
  parameter int PTR_W    = 14,
  parameter int ST_W     = 81 + 2*(PTR_W+1)
);
  logic                sched_tx_val;
  logic [FLOWID_W-1:0] sched_tx_flowid;
  logic                sched_tx_rdy;

  logic                tx_state_rd_req_val;
  logic [FLOWID_W-1:0] tx_state_rd_req_addr;
  logic                tx_state_rd_req_rdy;

  logic                tx_state_rd_resp_val;
  logic [ST_W-1:0]     tx_state_rd_resp_data;
  logic                tx_state_rd_resp_rdy;

  logic                tx_state_wr_req_val;
  logic [FLOWID_W-1:0] tx_state_wr_req_addr;
  logic [ST_W-1:0]     tx_state_wr_req_data;
  logic                tx_state_wr_req_rdy;

  logic [15:0]         adv_win;

  logic                send_pkt_enq_val;
  logic                send_pkt_enq_rdy;
  logic [FLOWID_W-1:0] send_pkt_enq_flowid;
  logic [31:0]         send_pkt_enq_seq;
  logic [31:0]         send_pkt_enq_ack;
  logic [7:0]          send_pkt_enq_flags;
  logic [15:0]         send_pkt_enq_win;
  logic [PTR_W:0]      send_pkt_enq_payload_ptr;
  logic [15:0]         send_pkt_enq_payload_len;

  modport master (
    input  sched_tx_val, sched_tx_flowid, output sched_tx_rdy,
    output tx_state_rd_req_val, tx_state_rd_req_addr, input tx_state_rd_req_rdy,
    input  tx_state_rd_resp_val, tx_state_rd_resp_data, output tx_state_rd_resp_rdy,
    output tx_state_wr_req_val, tx_state_wr_req_addr, tx_state_wr_req_data,
    input  tx_state_wr_req_rdy,
    input  adv_win,
    output send_pkt_enq_val, input send_pkt_enq_rdy,
    output send_pkt_enq_flowid, send_pkt_enq_seq, send_pkt_enq_ack, send_pkt_enq_flags,
    output send_pkt_enq_win, send_pkt_enq_payload_ptr, send_pkt_enq_payload_len
  );

  modport slave (
    output sched_tx_val, sched_tx_flowid, input sched_tx_rdy,
    input  tx_state_rd_req_val, tx_state_rd_req_addr, output tx_state_rd_req_rdy,
    output tx_state_rd_resp_val, tx_state_rd_resp_data, input tx_state_rd_resp_rdy,
    input  tx_state_wr_req_val, tx_state_wr_req_addr, tx_state_wr_req_data,
    output tx_state_wr_req_rdy,
    output adv_win,
    input  send_pkt_enq_val, output send_pkt_enq_rdy,
    input  send_pkt_enq_flowid, send_pkt_enq_seq, send_pkt_enq_ack, send_pkt_enq_flags,
    input  send_pkt_enq_win, send_pkt_enq_payload_ptr, send_pkt_enq_payload_len
  );
endinterface

// File: rtl/tcp_tx_seg_gen.sv
// TCP transmit segment generator: read flow state, size next segment, write back and enqueue.
// Optional: define TCP_TX_PURE_ACK_EN to emit zero-length ACK segments when ack_pending is set.
module tcp_tx_seg_gen #(
  parameter int FLOWID_W = 3,
  parameter int PTR_W    = 14,
  parameter int MSS_P    = 1460,
  parameter int ST_W     = 81 + 2*(PTR_W+1)
) (
  input  logic clk,
  input  logic rst,
  tcp_tx_seg_gen_if.master bus
);
  localparam int PW = PTR_W + 1;
  localparam logic [PW-1:0] AVAIL_MAX = {1'b1, {PTR_W{1'b0}}};
  localparam logic [15:0]   MSS16     = 16'(MSS_P);

  typedef struct packed {
    logic [31:0]   seq;
    logic [31:0]   ack;
    logic [15:0]   peer_win;
    logic [PW-1:0] snd_ptr;
    logic [PW-1:0] tail_ptr;
    logic          ack_pending;
  } tx_st_t;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, CALC, OUT} state_t;

  state_t              state_q, state_d;
  logic [FLOWID_W-1:0] flowid_q;
  tx_st_t              st_q, wr_data_q;
  logic                wr_done_q, enq_done_q;
  logic [31:0]         enq_seq_q, enq_ack_q;
  logic [7:0]          enq_flags_q;
  logic [15:0]         enq_win_q, enq_len_q;
  logic [PW-1:0]       enq_ptr_q;

  logic [PW-1:0] avail_raw, avail;
  logic [15:0]   len_am, seg_len;
  logic          psh, send, ap_next;
  logic          wr_fire, enq_fire;

  always_comb begin
    avail_raw = st_q.tail_ptr - st_q.snd_ptr;
    // more than a full buffer outstanding means the pointers are corrupt
    avail     = (avail_raw > AVAIL_MAX) ? '0 : avail_raw;
    len_am    = (32'(avail) > 32'(MSS_P)) ? MSS16 : 16'(avail);
    seg_len   = (len_am < st_q.peer_win) ? len_am : st_q.peer_win;
    psh       = (seg_len != 16'd0) && (32'(seg_len) == 32'(avail));
`ifdef TCP_TX_PURE_ACK_EN
    send      = (seg_len != 16'd0) || st_q.ack_pending;
    ap_next   = 1'b0;
`else
    send      = (seg_len != 16'd0);
    ap_next   = st_q.ack_pending;
`endif
  end

  assign wr_fire  = bus.tx_state_wr_req_val & bus.tx_state_wr_req_rdy;
  assign enq_fire = bus.send_pkt_enq_val & bus.send_pkt_enq_rdy;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.sched_tx_val)         state_d = RD_REQ;
      RD_REQ:  if (bus.tx_state_rd_req_rdy)  state_d = RD_WAIT;
      RD_WAIT: if (bus.tx_state_rd_resp_val) state_d = CALC;
      CALC:    state_d = send ? OUT : IDLE;
      OUT:     if ((wr_done_q | wr_fire) && (enq_done_q | enq_fire)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      flowid_q    <= '0;
      st_q        <= '0;
      wr_data_q   <= '0;
      wr_done_q   <= 1'b0;
      enq_done_q  <= 1'b0;
      enq_seq_q   <= '0;
      enq_ack_q   <= '0;
      enq_flags_q <= '0;
      enq_win_q   <= '0;
      enq_len_q   <= '0;
      enq_ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE:    if (bus.sched_tx_val) flowid_q <= bus.sched_tx_flowid;
        RD_WAIT: if (bus.tx_state_rd_resp_val) st_q <= tx_st_t'(bus.tx_state_rd_resp_data);
        CALC: begin
          enq_seq_q   <= st_q.seq;
          enq_ack_q   <= st_q.ack;
          enq_flags_q <= psh ? 8'h18 : 8'h10;
          enq_win_q   <= bus.adv_win;
          enq_len_q   <= seg_len;
          enq_ptr_q   <= st_q.snd_ptr;
          wr_data_q   <= '{seq:         st_q.seq + 32'(seg_len),
                           ack:         st_q.ack,
                           peer_win:    st_q.peer_win,
                           snd_ptr:     st_q.snd_ptr + PW'(seg_len),
                           tail_ptr:    st_q.tail_ptr,
                           ack_pending: ap_next};
        end
        OUT: begin
          if (wr_fire)  wr_done_q  <= 1'b1;
          if (enq_fire) enq_done_q <= 1'b1;
        end
        default: ;
      endcase
      if (state_d == IDLE) begin
        wr_done_q  <= 1'b0;
        enq_done_q <= 1'b0;
      end
    end
  end

  assign bus.sched_tx_rdy             = (state_q == IDLE);
  assign bus.tx_state_rd_req_val      = (state_q == RD_REQ);
  assign bus.tx_state_rd_req_addr     = flowid_q;
  assign bus.tx_state_rd_resp_rdy     = (state_q == RD_WAIT);
  assign bus.tx_state_wr_req_val      = (state_q == OUT) && !wr_done_q;
  assign bus.tx_state_wr_req_addr     = flowid_q;
  assign bus.tx_state_wr_req_data     = wr_data_q;
  assign bus.send_pkt_enq_val         = (state_q == OUT) && !enq_done_q;
  assign bus.send_pkt_enq_flowid      = flowid_q;
  assign bus.send_pkt_enq_seq         = enq_seq_q;
  assign bus.send_pkt_enq_ack         = enq_ack_q;
  assign bus.send_pkt_enq_flags       = enq_flags_q;
  assign bus.send_pkt_enq_win         = enq_win_q;
  assign bus.send_pkt_enq_payload_ptr = enq_ptr_q;
  assign bus.send_pkt_enq_payload_len = enq_len_q;
endmodule

// File: tb/tb_tcp_tx_seg_gen.sv
// Randomized bench for tcp_tx_seg_gen against an arithmetic reference of segment sizing.
module tb_tcp_tx_seg_gen;
  localparam int FLOWID_W = 3;
  localparam int PTR_W    = 14;
  localparam int PW       = PTR_W + 1;
  localparam int MSS_P    = 1460;
  localparam int ST_W     = 81 + 2*PW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tcp_tx_seg_gen_if #(.FLOWID_W(FLOWID_W), .PTR_W(PTR_W), .ST_W(ST_W)) bus ();
  tcp_tx_seg_gen #(.FLOWID_W(FLOWID_W), .PTR_W(PTR_W), .MSS_P(MSS_P), .ST_W(ST_W))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    bit              send;
    logic [31:0]     seq;
    logic [31:0]     ack;
    logic [7:0]      flags;
    logic [15:0]     win;
    logic [PW-1:0]   ptr;
    logic [15:0]     len;
    logic [ST_W-1:0] wr;
  } exp_t;

  function automatic logic [ST_W-1:0] mk(input logic [31:0] seq, input logic [31:0] ack,
      input logic [15:0] pw, input int snd, input int tail, input bit ap);
    logic [PW-1:0] s, t;
    s = PW'(snd);
    t = PW'(tail);
    return {seq, ack, pw, s, t, ap};
  endfunction

  // Reference: what the next segment of a flow should look like, from plain arithmetic.
  function automatic exp_t model(input logic [ST_W-1:0] st, input logic [15:0] aw);
    exp_t e;
    logic [31:0] seq, ack;
    logic [15:0] pw;
    int snd, tail, avail, len;
    bit ap;
    seq   = st[ST_W-1 -: 32];
    ack   = st[ST_W-33 -: 32];
    pw    = st[ST_W-65 -: 16];
    snd   = int'(st[2*PW:PW+1]);
    tail  = int'(st[PW:1]);
    ap    = st[0];
    avail = tail - snd;
    if (avail < 0) avail += (1 << PW);
    if (avail > (1 << PTR_W)) avail = 0;
    len = avail;
    if (len > MSS_P) len = MSS_P;
    if (len > int'(pw)) len = int'(pw);
    e.send  = (len > 0);
    e.flags = (len > 0 && len == avail) ? 8'h18 : 8'h10;
    e.seq   = seq;
    e.ack   = ack;
    e.win   = aw;
    e.ptr   = PW'(snd);
    e.len   = 16'(len);
`ifdef TCP_TX_PURE_ACK_EN
    e.send  = e.send || ap;
    ap      = 1'b0;
`endif
    e.wr = mk(seq + 32'(len), ack, pw, snd + len, tail, ap);
    return e;
  endfunction

  // mode 0: random ready/response timing, 1: everything ready, 2: enqueue held off 5 cycles
  task automatic run_cmd(input int flow, input logic [ST_W-1:0] st, input int mode);
    exp_t e;
    int cyc, wr_n, enq_n, enq_hi, fire_cyc;
    bit resp_pend, hold_v, done;
    logic [127:0] cur, hold;
    logic [15:0] aw;
    aw = 16'($urandom);
    e  = model(st, aw);
    cyc = 0; wr_n = 0; enq_n = 0; enq_hi = 0; fire_cyc = -10;
    resp_pend = 0; hold_v = 0; done = 0; hold = '0;
    @(negedge clk);
    bus.adv_win         = aw;
    bus.sched_tx_val    = 1'b1;
    bus.sched_tx_flowid = FLOWID_W'(flow);
    #1 chk("sched_rdy_idle", bus.sched_tx_rdy, 1'b1);
    while (cyc < 80 && !done) begin
      @(negedge clk);
      cyc++;
      bus.sched_tx_val = 1'b0;
      if (bus.sched_tx_rdy) begin
        done = 1;
      end else begin
        bus.tx_state_rd_resp_data = st;
        if (mode == 0) begin
          bus.tx_state_rd_req_rdy  = 1'($urandom_range(0, 1));
          bus.tx_state_wr_req_rdy  = 1'($urandom_range(0, 1));
          bus.send_pkt_enq_rdy     = 1'($urandom_range(0, 1));
          bus.tx_state_rd_resp_val = resp_pend && ($urandom_range(0, 1) == 1);
        end else begin
          bus.tx_state_rd_req_rdy  = 1'b1;
          bus.tx_state_wr_req_rdy  = 1'b1;
          bus.send_pkt_enq_rdy     = (mode == 2) ? (enq_hi >= 5) : 1'b1;
          bus.tx_state_rd_resp_val = resp_pend;
        end
        #1;
        if (bus.tx_state_rd_req_val && bus.tx_state_rd_req_rdy) begin
          chk("rd_addr", bus.tx_state_rd_req_addr, flow);
          resp_pend = 1;
        end
        if (bus.tx_state_rd_resp_val && bus.tx_state_rd_resp_rdy) resp_pend = 0;
        if (bus.tx_state_wr_req_val && bus.tx_state_wr_req_rdy) begin
          wr_n++;
          chk("wr_addr", bus.tx_state_wr_req_addr, flow);
          chk("wr_data", bus.tx_state_wr_req_data, e.wr);
        end
        if (bus.send_pkt_enq_val) begin
          cur = {bus.send_pkt_enq_flowid, bus.send_pkt_enq_seq, bus.send_pkt_enq_ack,
                 bus.send_pkt_enq_flags, bus.send_pkt_enq_win, bus.send_pkt_enq_payload_ptr,
                 bus.send_pkt_enq_payload_len};
          if (hold_v) chk("enq_stable", cur, hold);
          hold = cur; hold_v = 1; enq_hi++;
          if (bus.send_pkt_enq_rdy) begin
            enq_n++; fire_cyc = cyc; hold_v = 0;
            chk("enq_flowid", bus.send_pkt_enq_flowid, flow);
            chk("enq_seq", bus.send_pkt_enq_seq, e.seq);
            chk("enq_ack", bus.send_pkt_enq_ack, e.ack);
            chk("enq_flags", bus.send_pkt_enq_flags, e.flags);
            chk("enq_win", bus.send_pkt_enq_win, e.win);
            chk("enq_ptr", bus.send_pkt_enq_payload_ptr, e.ptr);
            chk("enq_len", bus.send_pkt_enq_payload_len, e.len);
          end
        end
      end
    end
    chk("idle_reached", done, 1'b1);
    chk("wr_count", wr_n, e.send);
    chk("enq_count", enq_n, e.send);
    if (mode == 1) chk("latency", cyc, e.send ? 5 : 4);
    if (mode == 2) chk("idle_after_enq", cyc, fire_cyc + 1);
    bus.tx_state_rd_req_rdy  = 1'b0;
    bus.tx_state_wr_req_rdy  = 1'b0;
    bus.send_pkt_enq_rdy     = 1'b0;
    bus.tx_state_rd_resp_val = 1'b0;
  endtask

  task automatic reset_in_rd_wait();
    int seen;
    seen = 0;
    @(negedge clk);
    bus.sched_tx_val = 1'b1; bus.sched_tx_flowid = 3'd5;
    @(negedge clk);
    bus.sched_tx_val = 1'b0; bus.tx_state_rd_req_rdy = 1'b1;
    #1 chk("rst_test_rd_req", bus.tx_state_rd_req_val, 1'b1);
    @(negedge clk);
    chk("rst_test_rd_wait", bus.tx_state_rd_resp_rdy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_vals", {bus.tx_state_rd_req_val, bus.tx_state_rd_resp_rdy,
                     bus.tx_state_wr_req_val, bus.send_pkt_enq_val}, 4'b0);
    chk("rst_sched_rdy", bus.sched_tx_rdy, 1'b1);
    bus.tx_state_rd_resp_data = mk(32'h55, 32'h66, 16'hFFFF, 0, 100, 1'b1);
    bus.tx_state_rd_resp_val  = 1'b1;
    bus.tx_state_wr_req_rdy   = 1'b1;
    bus.send_pkt_enq_rdy      = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.tx_state_wr_req_val || bus.send_pkt_enq_val) seen++;
    end
    chk("rst_no_issue", seen, 0);
    bus.tx_state_rd_resp_val = 1'b0;
    bus.tx_state_rd_req_rdy  = 1'b0;
    bus.tx_state_wr_req_rdy  = 1'b0;
    bus.send_pkt_enq_rdy     = 1'b0;
  endtask

  initial begin
    logic [ST_W-1:0] st;
    int snd, off;
    logic [15:0] pw;
    bus.sched_tx_val = 0; bus.sched_tx_flowid = '0;
    bus.tx_state_rd_req_rdy = 0; bus.tx_state_rd_resp_val = 0; bus.tx_state_rd_resp_data = '0;
    bus.tx_state_wr_req_rdy = 0; bus.send_pkt_enq_rdy = 0; bus.adv_win = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_vals", {bus.tx_state_rd_req_val, bus.tx_state_rd_resp_rdy,
                       bus.tx_state_wr_req_val, bus.send_pkt_enq_val}, 4'b0);
    chk("reset_sched_rdy", bus.sched_tx_rdy, 1'b1);
    chk("reset_wr_data", bus.tx_state_wr_req_data, '0);
    chk("reset_enq_desc", {bus.send_pkt_enq_seq, bus.send_pkt_enq_flags,
                           bus.send_pkt_enq_payload_len}, '0);

    run_cmd(2, mk(32'h1000, 32'h2222, 16'hFFFF, 'h10, 'h110, 1'b0), 1);     // basic send
    run_cmd(1, mk(32'hFFFFFF00, 32'h1, 16'hFFFF, 'h7FF0, 'h0800, 1'b0), 1); // MSS clamp, wraps
    run_cmd(3, mk(32'h40, 32'h2, 16'd100, 'h100, 'h100 + 500, 1'b0), 1);    // window clamp
    run_cmd(4, mk(32'h80, 32'h3, 16'd0, 'h200, 'h300, 1'b0), 1);            // zero window
    run_cmd(6, mk(32'h90, 32'h4, 16'hFFFF, 'h321, 'h321, 1'b1), 1);         // pure ACK case
    run_cmd(7, mk(32'hA0, 32'h5, 16'hFFFF, 'h10, 'h50, 1'b1), 2);           // enqueue backpressure
    reset_in_rd_wait();

    for (int i = 0; i < 60; i++) begin
      snd = int'($urandom_range(0, (1 << PW) - 1));
      case ($urandom_range(0, 5))
        0:       off = 0;
        1:       off = int'($urandom_range(1, 200));
        2:       off = int'($urandom_range(1000, 3000));
        3:       off = int'($urandom_range(1, 1 << PTR_W));
        4:       off = int'($urandom_range((1 << PTR_W) + 1, (1 << PW) - 1));
        default: off = 1 << PTR_W;
      endcase
      case ($urandom_range(0, 3))
        0:       pw = 16'd0;
        1:       pw = 16'($urandom_range(1, 200));
        2:       pw = 16'hFFFF;
        default: pw = 16'($urandom);
      endcase
      st = mk($urandom, $urandom, pw, snd, snd + off, 1'($urandom_range(0, 1)));
      run_cmd(int'($urandom_range(0, 7)), st, (i % 4 == 3) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
